// File: rtl/adc_avg_pkg.sv
// Shared types and constants for the ADC averaging decimator.
// The output register FSM state type and the rounding constant live here.
package adc_avg_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  localparam int ADC_DATA_W = 16;
  localparam int ADC_LOG2_N = 4;

  // Half an LSB of the averaged result, added before the divide so that
  // the shift rounds to nearest (ties up); zero when there is no divide.
  function automatic int unsigned round_const(input int log2n);
    return (log2n == 0) ? 32'd0 : (32'd1 << (log2n - 1));
  endfunction

endpackage

// File: rtl/adc_minmax_track.sv
// Per-window minimum/maximum tracker; window_min/max include the current sample.
// Used by adc_avg_decim only when ADC_AVG_MINMAX_EN is defined.
module adc_minmax_track
  import adc_avg_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_vld_i,
  input  logic              first_i,
  output logic [DATA_W-1:0] win_min_o,
  output logic [DATA_W-1:0] win_max_o
);

  logic [DATA_W-1:0] min_reg;
  logic [DATA_W-1:0] max_reg;

  // The first sample of a window re-seeds both extremes, so no explicit
  // per-window reset is needed.
  always_comb begin
    win_min_o = (first_i || (sample_i < min_reg)) ? sample_i : min_reg;
    win_max_o = (first_i || (sample_i > max_reg)) ? sample_i : max_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_reg <= '0;
      max_reg <= '0;
    end else if (sample_vld_i) begin
      min_reg <= win_min_o;
      max_reg <= win_max_o;
    end
  end

endmodule

// File: rtl/adc_avg_decim.sv
// Averages 2**LOG2_N ADC samples, rounds to nearest and presents the result on a valid/ready register.
// Optional per-window min/max outputs are enabled by defining ADC_AVG_MINMAX_EN.
module adc_avg_decim
  import adc_avg_pkg::*;
#(
  parameter int  DATA_W = ADC_DATA_W,
  parameter int  LOG2_N = ADC_LOG2_N,
  parameter int  ACC_W  = DATA_W + LOG2_N + 1,
  localparam int CNT_W  = (LOG2_N == 0) ? 1 : LOG2_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_vld_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] avg_o,
  output logic              avg_vld_o,
  input  logic              avg_rdy_i,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  fill_cnt_o
`ifdef ADC_AVG_MINMAX_EN
  ,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o
`endif
);

  localparam int                N        = 1 << LOG2_N;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
  localparam logic [ACC_W-1:0]  RND      = ACC_W'(round_const(LOG2_N));
  localparam logic [DATA_W-1:0] AVG_MAX  = '1;

  out_state_t        state_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] avg_reg;
  logic              overrun_reg;

  logic [ACC_W-1:0]  sum_next;
  logic [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0] result;
  logic              win_done;
  logic              load_out;

  // Sum including the sample arriving this cycle, so the completing sample
  // is folded into the result without an extra clock.
  always_comb begin
    sum_next = acc_reg + ACC_W'(sample_i);
    shifted  = (sum_next + RND) >> LOG2_N;
    result   = (|shifted[ACC_W-1:DATA_W]) ? AVG_MAX : shifted[DATA_W-1:0];
  end

  assign win_done = sample_vld_i && (cnt_reg == CNT_LAST);
  assign load_out = !clear_i && win_done && ((state_reg == ST_EMPTY) || avg_rdy_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_EMPTY;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      avg_reg     <= '0;
      overrun_reg <= 1'b0;
    end else if (clear_i) begin
      state_reg   <= ST_EMPTY;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (sample_vld_i) begin
        if (win_done) begin
          acc_reg <= '0;
          cnt_reg <= '0;
        end else begin
          acc_reg <= sum_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      if (load_out) avg_reg <= result;
      case (state_reg)
        ST_EMPTY: begin
          if (win_done) state_reg <= ST_FULL;
        end
        ST_FULL: begin
          // A completion with the consumer stalled drops the new result.
          if (win_done && !avg_rdy_i) overrun_reg <= 1'b1;
          else if (!win_done && avg_rdy_i) state_reg <= ST_EMPTY;
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign avg_o      = avg_reg;
  assign avg_vld_o  = (state_reg == ST_FULL);
  assign overrun_o  = overrun_reg;
  assign fill_cnt_o = cnt_reg;

`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] win_min;
  logic [DATA_W-1:0] win_max;
  logic [DATA_W-1:0] min_reg;
  logic [DATA_W-1:0] max_reg;

  adc_minmax_track #(
    .DATA_W (DATA_W)
  ) u_minmax (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_i     (sample_i),
    .sample_vld_i (sample_vld_i && !clear_i),
    .first_i      (cnt_reg == '0),
    .win_min_o    (win_min),
    .win_max_o    (win_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_reg <= '0;
      max_reg <= '0;
    end else if (load_out) begin
      min_reg <= win_min;
      max_reg <= win_max;
    end
  end

  assign min_o = min_reg;
  assign max_o = max_reg;
`endif

endmodule

// File: tb/tb_adc_avg_decim.sv
// Directed, table-driven bench for adc_avg_decim (N = 16).
// Define ADC_AVG_MINMAX_EN to also exercise the min/max outputs.
module tb_adc_avg_decim;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample_i;
  logic        sample_vld_i;
  logic        clear_i;
  logic [15:0] avg_o;
  logic        avg_vld_o;
  logic        avg_rdy_i;
  logic        overrun_o;
  logic [3:0]  fill_cnt_o;
`ifdef ADC_AVG_MINMAX_EN
  logic [15:0] min_o;
  logic [15:0] max_o;
`endif

  int n_cmp;
  int n_bad;

  adc_avg_decim dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_i     (sample_i),
    .sample_vld_i (sample_vld_i),
    .clear_i      (clear_i),
    .avg_o        (avg_o),
    .avg_vld_o    (avg_vld_o),
    .avg_rdy_i    (avg_rdy_i),
    .overrun_o    (overrun_o),
    .fill_cnt_o   (fill_cnt_o)
`ifdef ADC_AVG_MINMAX_EN
    ,
    .min_o        (min_o),
    .max_o        (max_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] s_even;
    logic [15:0] s_odd;
    logic [15:0] s_last;
    logic [15:0] exp_avg;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] s);
    sample_i     = s;
    sample_vld_i = 1'b1;
    tick();
    sample_vld_i = 1'b0;
  endtask

  // 16 back-to-back strobes; rdy_last applies only during the completing strobe.
  task automatic run_window(input logic [15:0] s, input logic rdy_rest, input logic rdy_last);
    for (int i = 0; i < 16; i++) begin
      avg_rdy_i = (i == 15) ? rdy_last : rdy_rest;
      strobe(s);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n        = 1'b0;
    sample_i     = '0;
    sample_vld_i = 1'b0;
    clear_i      = 1'b0;
    avg_rdy_i    = 1'b1;

    // Averages: alternating even/odd samples, last sample overridden.
    tbl[0] = '{"flat_1000",  16'h1000, 16'h1000, 16'h1000, 16'h1000};
    tbl[1] = '{"half_up",    16'd0,    16'd1,    16'd1,    16'd1};
    tbl[2] = '{"all_ffff",   16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[3] = '{"round_down", 16'd0,    16'd0,    16'd7,    16'd0};
    tbl[4] = '{"round_up",   16'd0,    16'd0,    16'd8,    16'd1};
    tbl[5] = '{"exact_150",  16'd100,  16'd200,  16'd200,  16'd150};
    tbl[6] = '{"near_5",     16'd5,    16'd5,    16'd0,    16'd5};

    repeat (3) tick();
    chk("rst_avg", 32'(avg_o), 32'h0);
    chk("rst_vld", 32'(avg_vld_o), 32'h0);
    chk("rst_ovr", 32'(overrun_o), 32'h0);
    chk("rst_cnt", 32'(fill_cnt_o), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      avg_rdy_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
        strobe((i == 15) ? tbl[v].s_last : ((i % 2) ? tbl[v].s_odd : tbl[v].s_even));
        if (i == 14) begin
          chk({tbl[v].name, "_cnt15"}, 32'(fill_cnt_o), 32'd15);
          chk({tbl[v].name, "_novld"}, 32'(avg_vld_o), 32'h0);
        end
      end
      chk({tbl[v].name, "_avg"}, 32'(avg_o), 32'(tbl[v].exp_avg));
      chk({tbl[v].name, "_vld"}, 32'(avg_vld_o), 32'h1);
      chk({tbl[v].name, "_cnt0"}, 32'(fill_cnt_o), 32'h0);
      tick();
      chk({tbl[v].name, "_vld1clk"}, 32'(avg_vld_o), 32'h0);
    end

    // Async reset mid-window, then a clean window.
    for (int i = 0; i < 7; i++) strobe(16'h1234);
    chk("mid_cnt7", 32'(fill_cnt_o), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt", 32'(fill_cnt_o), 32'h0);
    chk("async_avg", 32'(avg_o), 32'h0);
    chk("async_vld", 32'(avg_vld_o), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_window(16'h1000, 1'b1, 1'b1);
    chk("post_rst_avg", 32'(avg_o), 32'h1000);
    chk("post_rst_vld", 32'(avg_vld_o), 32'h1);
    tick();

    // Stalled consumer: second window overruns, first result held.
    run_window(16'd100, 1'b0, 1'b0);
    chk("stall1_avg", 32'(avg_o), 32'd100);
    chk("stall1_ovr", 32'(overrun_o), 32'h0);
    run_window(16'd200, 1'b0, 1'b0);
    chk("stall2_avg", 32'(avg_o), 32'd100);
    chk("stall2_vld", 32'(avg_vld_o), 32'h1);
    chk("stall2_ovr", 32'(overrun_o), 32'h1);
    tick();
    chk("ovr_sticky", 32'(overrun_o), 32'h1);
    clear_i = 1'b1;
    strobe(16'd77);
    clear_i = 1'b0;
    chk("clr_ovr", 32'(overrun_o), 32'h0);
    chk("clr_vld", 32'(avg_vld_o), 32'h0);
    chk("clr_avg", 32'(avg_o), 32'd100);
    chk("clr_cnt", 32'(fill_cnt_o), 32'h0);

    // Accept and completion in the same cycle while FULL.
    run_window(16'd50, 1'b0, 1'b0);
    chk("full_avg50", 32'(avg_o), 32'd50);
    run_window(16'd60, 1'b0, 1'b1);
    chk("swap_avg", 32'(avg_o), 32'd60);
    chk("swap_vld", 32'(avg_vld_o), 32'h1);
    chk("swap_ovr", 32'(overrun_o), 32'h0);
    avg_rdy_i = 1'b1;
    tick();
    chk("swap_drain", 32'(avg_vld_o), 32'h0);

    // Clear discards an in-progress window and a coincident sample.
    for (int i = 0; i < 5; i++) strobe(16'd9);
    chk("part_cnt5", 32'(fill_cnt_o), 32'd5);
    clear_i = 1'b1;
    strobe(16'hFFFF);
    clear_i = 1'b0;
    chk("clr_part_cnt", 32'(fill_cnt_o), 32'h0);
    run_window(16'd20, 1'b1, 1'b1);
    chk("after_clr_avg", 32'(avg_o), 32'd20);
    tick();

`ifdef ADC_AVG_MINMAX_EN
    avg_rdy_i = 1'b1;
    strobe(16'd5);
    strobe(16'd900);
    strobe(16'd3);
    for (int i = 0; i < 13; i++) strobe(16'd7);
    chk("mm_avg", 32'(avg_o), 32'd62);
    chk("mm_min", 32'(min_o), 32'd3);
    chk("mm_max", 32'(max_o), 32'd900);
    tick();
    run_window(16'd40, 1'b1, 1'b1);
    chk("mm_reseed_min", 32'(min_o), 32'd40);
    chk("mm_reseed_max", 32'(max_o), 32'd40);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
